nios2_system_v0_cpu_cpu_debug_ocimem: RTL and testbench

//  Debug-side on-chip memory controller for the Nios II OCI. Consumes jdo and the

---
 rtl/nios2_system_v0_cpu_debug_pkg.sv | 9 +
 rtl/nios2_system_v0_cpu_cpu_debug_ocimem_ram.sv | 19 +
 rtl/nios2_system_v0_cpu_cpu_debug_ocimem.sv | 80 ++++++++
 tb/tb_nios2_system_v0_cpu_cpu_debug_ocimem.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_system_v0_cpu_debug_pkg.sv
// nios2_system_v0_cpu_debug_pkg: shared state encoding and jdo field layout for the OCI debug memory
package nios2_system_v0_cpu_debug_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_LSB = 26;
  localparam int RD_BIT = 34;
  localparam int CLR_OVR_BIT = 35;
  localparam int WDATA_LSB = 3;
  typedef enum logic [2:0] {IDLE, J_RD, J_WR, C_RD, C_WR} ocimem_state_t;
endpackage

// File: rtl/nios2_system_v0_cpu_cpu_debug_ocimem_ram.sv
// nios2_system_v0_cpu_cpu_debug_ocimem_ram: single-port sync RAM, byte enables, 1-cycle read
module nios2_system_v0_cpu_cpu_debug_ocimem_ram
  import nios2_system_v0_cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    q <= mem[addr];
  end
endmodule

// File: rtl/nios2_system_v0_cpu_cpu_debug_ocimem.sv
// nios2_system_v0_cpu_cpu_debug_ocimem: arbitrates the debug RAM between JTAG commands and the CPU slave
module nios2_system_v0_cpu_cpu_debug_ocimem
  import nios2_system_v0_cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [37:0]         jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [3:0]          byteenable,
  input  logic                debugaccess,
  output logic [DATA_W-1:0]   readdata,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                ocimem_overrun
);
  ocimem_state_t state;
  logic [ADDR_W-1:0] mon_areg, mon_areg_nxt, ram_addr;
  logic [DATA_W-1:0] wdata, wdata_nxt, ram_q, ram_wdata;
  logic [3:0] ram_we;
  logic pend_rd, pend_wr, pend_rd_nxt, pend_wr_nxt;
  logic strobe, busy, accept, ld_wr, jtag_go, ovr_nxt;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  // A strobe arriving in IDLE is acted on in the same cycle, so JTAG wins over a concurrent CPU request.
  always_comb begin
    strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    busy = pend_rd | pend_wr;
    accept = strobe & ~busy;
    ld_wr = accept & ~take_action_ocimem_a & ~take_no_action_ocimem_a;
    mon_areg_nxt = ~accept ? mon_areg :
                   take_action_ocimem_a ? jdo[ADDR_LSB +: ADDR_W] :
                   take_no_action_ocimem_a ? mon_areg + ADDR_W'(1) : mon_areg;
    pend_rd_nxt = pend_rd | (accept & (take_action_ocimem_a ? jdo[RD_BIT] : take_no_action_ocimem_a));
    pend_wr_nxt = pend_wr | ld_wr;
    wdata_nxt = ld_wr ? jdo[WDATA_LSB +: DATA_W] : wdata;
    ovr_nxt = (strobe & busy) | (ocimem_overrun & ~(accept & take_action_ocimem_a & jdo[CLR_OVR_BIT]));
    jtag_go = pend_rd_nxt | pend_wr_nxt;
    ram_addr = (state == IDLE && jtag_go) ? mon_areg_nxt : state == J_WR ? mon_areg : address;
    ram_we = state == J_WR ? 4'hF : (state == C_WR && debugaccess) ? byteenable : 4'h0;
    ram_wdata = state == J_WR ? wdata : writedata;
    readdata = state == C_RD ? ram_q : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mon_areg <= '0;
      MonDReg <= '0;
      wdata <= '0;
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
      ocimem_overrun <= 1'b0;
      waitrequest <= 1'b1;
    end else begin
      state <= state != IDLE ? IDLE : pend_rd_nxt ? J_RD : pend_wr_nxt ? J_WR :
               read ? C_RD : write ? C_WR : IDLE;
      waitrequest <= ~(state == IDLE && ~jtag_go && (read | write));
      mon_areg <= state == J_WR ? mon_areg + ADDR_W'(1) : mon_areg_nxt;
      MonDReg <= state == J_RD ? ram_q : MonDReg;
      pend_rd <= pend_rd_nxt & (state != J_RD);
      pend_wr <= pend_wr_nxt & (state != J_WR);
      wdata <= wdata_nxt;
      ocimem_overrun <= ovr_nxt;
    end
  end
  nios2_system_v0_cpu_cpu_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .addr(ram_addr),
    .we(ram_we),
    .wdata(ram_wdata),
    .q(ram_q)
  );
endmodule

// File: tb/tb_nios2_system_v0_cpu_cpu_debug_ocimem.sv
// tb_nios2_system_v0_cpu_cpu_debug_ocimem: directed vector table plus hand sequences for arbitration corners
module tb_nios2_system_v0_cpu_cpu_debug_ocimem;
  logic clk = 1'b0;
  logic reset_n;
  logic [37:0] jdo;
  logic take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0] address;
  logic read, write, debugaccess;
  logic [31:0] writedata, readdata, MonDReg;
  logic [3:0] byteenable;
  logic waitrequest, ocimem_overrun;
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  nios2_system_v0_cpu_cpu_debug_ocimem #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .debugaccess(debugaccess), .readdata(readdata),
    .waitrequest(waitrequest), .MonDReg(MonDReg), .ocimem_overrun(ocimem_overrun)
  );

  typedef enum {CW, CR, JA, JN, JB, CHKM} op_t;
  typedef struct {
    op_t op;
    logic [7:0] addr;
    logic [31:0] data;
    logic [3:0] be;
    logic dbg;
    logic [31:0] exp;
  } vec_t;
  vec_t v[$];

  function automatic logic [37:0] ja(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j = '0;
    j[33:26] = a;
    j[34] = rd;
    j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    logic [37:0] j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic jtag(input logic a, input logic na, input logic b, input logic [37:0] j);
    @(negedge clk);
    take_action_ocimem_a = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b = b;
    jdo = j;
    @(negedge clk);
    take_action_ocimem_a = 0;
    take_no_action_ocimem_a = 0;
    take_action_ocimem_b = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cpu(input logic rd, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic dbg, output logic [31:0] q, output int lat);
    @(negedge clk);
    read = rd;
    write = ~rd;
    address = a;
    writedata = d;
    byteenable = be;
    debugaccess = dbg;
    lat = 0;
    q = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (!waitrequest) begin
        lat = i;
        q = readdata;
        break;
      end
    end
    read = 0;
    write = 0;
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] q;
    int lat;
    reset_n = 0;
    jdo = '0;
    take_action_ocimem_a = 0;
    take_no_action_ocimem_a = 0;
    take_action_ocimem_b = 0;
    address = '0;
    read = 0;
    write = 0;
    writedata = '0;
    byteenable = '0;
    debugaccess = 0;

    v.push_back('{JA,   8'h10, 32'h0,        4'b0000, 1'b0, 32'h0});
    v.push_back('{JB,   8'h00, 32'hDEADBEEF, 4'b0000, 1'b0, 32'h0});
    v.push_back('{CR,   8'h10, 32'h0,        4'b0000, 1'b0, 32'hDEADBEEF});
    v.push_back('{JB,   8'h00, 32'hCAFE0011, 4'b0000, 1'b0, 32'h0});
    v.push_back('{CR,   8'h11, 32'h0,        4'b0000, 1'b0, 32'hCAFE0011});
    v.push_back('{CW,   8'h20, 32'h0,        4'b1111, 1'b1, 32'h0});
    v.push_back('{CW,   8'h20, 32'h11223344, 4'b0010, 1'b1, 32'h0});
    v.push_back('{JA,   8'h20, 32'h0,        4'b0001, 1'b0, 32'h0});
    v.push_back('{CHKM, 8'h00, 32'h0,        4'b0000, 1'b0, 32'h00003300});
    v.push_back('{CW,   8'h20, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0});
    v.push_back('{JA,   8'h20, 32'h0,        4'b0001, 1'b0, 32'h0});
    v.push_back('{CHKM, 8'h00, 32'h0,        4'b0000, 1'b0, 32'h00003300});
    v.push_back('{CR,   8'h20, 32'h0,        4'b0000, 1'b0, 32'h00003300});
    v.push_back('{CW,   8'h30, 32'h0,        4'b1111, 1'b1, 32'h0});
    v.push_back('{CW,   8'h30, 32'hAABBCCDD, 4'b1001, 1'b1, 32'h0});
    v.push_back('{CR,   8'h30, 32'h0,        4'b0000, 1'b0, 32'hAA0000DD});
    v.push_back('{CW,   8'h05, 32'h55555555, 4'b1111, 1'b1, 32'h0});
    v.push_back('{CW,   8'h06, 32'h66666666, 4'b1111, 1'b1, 32'h0});
    v.push_back('{CW,   8'h07, 32'h77777777, 4'b1111, 1'b1, 32'h0});
    v.push_back('{CW,   8'h08, 32'h88888888, 4'b1111, 1'b1, 32'h0});
    v.push_back('{CW,   8'h09, 32'h99999999, 4'b1111, 1'b1, 32'h0});
    v.push_back('{CW,   8'h00, 32'h0000A5A5, 4'b1111, 1'b1, 32'h0});
    v.push_back('{JA,   8'h05, 32'h0,        4'b0001, 1'b0, 32'h0});
    v.push_back('{CHKM, 8'h00, 32'h0,        4'b0000, 1'b0, 32'h55555555});
    v.push_back('{JN,   8'h00, 32'h0,        4'b0000, 1'b0, 32'h0});
    v.push_back('{CHKM, 8'h00, 32'h0,        4'b0000, 1'b0, 32'h66666666});
    v.push_back('{JA,   8'hFF, 32'h0,        4'b0000, 1'b0, 32'h0});
    v.push_back('{JN,   8'h00, 32'h0,        4'b0000, 1'b0, 32'h0});
    v.push_back('{CHKM, 8'h00, 32'h0,        4'b0000, 1'b0, 32'h0000A5A5});
    v.push_back('{JA,   8'hFF, 32'h0,        4'b0000, 1'b0, 32'h0});
    v.push_back('{JB,   8'h00, 32'h12345678, 4'b0000, 1'b0, 32'h0});
    v.push_back('{JB,   8'h00, 32'h9ABCDEF0, 4'b0000, 1'b0, 32'h0});
    v.push_back('{CR,   8'hFF, 32'h0,        4'b0000, 1'b0, 32'h12345678});
    v.push_back('{CR,   8'h00, 32'h0,        4'b0000, 1'b0, 32'h9ABCDEF0});

    repeat (3) @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    chk("reset_mondreg", MonDReg, 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_waitrequest", {31'h0, waitrequest}, 32'h1);
    chk("reset_overrun", {31'h0, ocimem_overrun}, 32'h0);

    foreach (v[k]) begin
      case (v[k].op)
        CW: begin
          cpu(1'b0, v[k].addr, v[k].data, v[k].be, v[k].dbg, q, lat);
          chk($sformatf("v%0d_cw_latency", k), lat, 1);
        end
        CR: begin
          cpu(1'b1, v[k].addr, 32'h0, 4'h0, 1'b0, q, lat);
          chk($sformatf("v%0d_cr_data", k), q, v[k].exp);
          chk($sformatf("v%0d_cr_latency", k), lat, 1);
        end
        JA: jtag(1'b1, 1'b0, 1'b0, ja(v[k].addr, v[k].be[0], v[k].be[1]));
        JN: jtag(1'b0, 1'b1, 1'b0, '0);
        JB: jtag(1'b0, 1'b0, 1'b1, jb(v[k].data));
        CHKM: chk($sformatf("v%0d_mondreg", k), MonDReg, v[k].exp);
      endcase
    end

    // CPU read and JTAG read strobe in the same cycle: JTAG goes first.
    @(negedge clk);
    read = 1;
    address = 8'h05;
    take_action_ocimem_a = 1;
    jdo = ja(8'h06, 1'b1, 1'b0);
    lat = 0;
    q = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      take_action_ocimem_a = 0;
      if (i == 2) chk("contend_mondreg_first", MonDReg, 32'h66666666);
      if (!waitrequest) begin
        lat = i;
        q = readdata;
        break;
      end
    end
    read = 0;
    @(posedge clk);
    chk("contend_latency", lat, 3);
    chk("contend_readdata", q, 32'h55555555);
    repeat (4) @(negedge clk);

    // Two strobes one clock apart during a held CPU read: second is dropped.
    @(negedge clk);
    read = 1;
    address = 8'h07;
    take_action_ocimem_a = 1;
    jdo = ja(8'h08, 1'b1, 1'b0);
    lat = 0;
    q = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      take_action_ocimem_a = (i == 1);
      jdo = ja(8'h09, 1'b1, 1'b0);
      if (!waitrequest) begin
        lat = i;
        q = readdata;
        break;
      end
    end
    read = 0;
    take_action_ocimem_a = 0;
    @(posedge clk);
    chk("overrun_latency", lat, 3);
    chk("overrun_readdata", q, 32'h77777777);
    repeat (4) @(negedge clk);
    chk("overrun_mondreg_kept", MonDReg, 32'h88888888);
    chk("overrun_set", {31'h0, ocimem_overrun}, 32'h1);
    jtag(1'b1, 1'b0, 1'b0, ja(8'h00, 1'b0, 1'b1));
    chk("overrun_cleared", {31'h0, ocimem_overrun}, 32'h0);

    // Reset asserted while the CPU read is being served.
    @(negedge clk);
    read = 1;
    address = 8'h09;
    @(posedge clk);
    #1;
    chk("crd_waitrequest_low", {31'h0, waitrequest}, 32'h0);
    chk("crd_readdata", readdata, 32'h99999999);
    reset_n = 0;
    #1;
    chk("rst_mid_waitrequest", {31'h0, waitrequest}, 32'h1);
    chk("rst_mid_readdata", readdata, 32'h0);
    chk("rst_mid_mondreg", MonDReg, 32'h0);
    read = 0;
    @(negedge clk);
    reset_n = 1;
    cpu(1'b1, 8'h09, 32'h0, 4'h0, 1'b0, q, lat);
    chk("rst_ram_kept", q, 32'h99999999);
    chk("rst_idle_latency", lat, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
